ila_seq_gen: RTL and testbench



---
 rtl/jesd204b_pkg.sv | 28 ++
 rtl/ila_seq_gen.sv | 153 +++++++++++++++
 tb/tb_ila_seq_gen.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/jesd204b_pkg.sv
// Shared JESD204B link-layer constants: K-character codes, ILAS config layout
// and the tx link mux select encoding.
package jesd204b_pkg;

   // K28.x control characters, HGFEDCBA octet values
   localparam logic [7:0] K28_0_R = 8'h1C;
   localparam logic [7:0] K28_3_A = 8'h7C;
   localparam logic [7:0] K28_4_Q = 8'h9C;
   localparam logic [7:0] K28_5_K = 8'hBC;

   // Link configuration octets carried in the second ILAS multiframe
   localparam int ILA_CFG_OCTETS    = 14;
   localparam int ILA_CFG_START_OCT = 2;
   localparam int ILA_CFG_W         = 8 * ILA_CFG_OCTETS;

   typedef enum logic [1:0] {
      LINK_SEL_USER = 2'd0,
      LINK_SEL_CGS  = 2'd1,
      LINK_SEL_ILA  = 2'd2,
      LINK_SEL_TEST = 2'd3
   } link_sel_t;

   typedef enum logic {
      ILA_IDLE = 1'b0,
      ILA_RUN  = 1'b1
   } ila_state_t;

endpackage

// File: rtl/ila_seq_gen.sv
// JESD204B initial lane alignment sequence generator for one lane: emits
// NUM_MF multiframes of F*K octets per start, config octets in multiframe 1.
module ila_seq_gen
   import jesd204b_pkg::*;
#(
   parameter int F      = 2,
   parameter int K      = 16,
   parameter int NUM_MF = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [ILA_CFG_W-1:0] i_cfg,
   output logic [7:0]           o_data,
   output logic                 o_vld,
   output logic                 o_k,
   output logic                 o_busy,
   output logic                 o_done
);

   localparam int FK   = F * K;
   localparam int OC_W = $clog2(FK);
   localparam int MC_W = (NUM_MF > 1) ? $clog2(NUM_MF) : 1;

   localparam logic [OC_W-1:0] OC_LAST = OC_W'(FK - 1);
   localparam logic [MC_W-1:0] MC_LAST = MC_W'(NUM_MF - 1);
   localparam logic [MC_W-1:0] MC_CFG  = MC_W'(1);

   // The /A/ octet must land after the last config octet of multiframe 1
   if (FK < ILA_CFG_START_OCT + ILA_CFG_OCTETS + 1) begin : g_bad_fk
      $error("ila_seq_gen: F*K must be >= 17");
   end
   if (F < 1 || F > 256) begin : g_bad_f
      $error("ila_seq_gen: F must be in 1..256");
   end
   if (K < 1 || K > 32) begin : g_bad_k
      $error("ila_seq_gen: K must be in 1..32");
   end
   if (NUM_MF < 1) begin : g_bad_mf
      $error("ila_seq_gen: NUM_MF must be >= 1");
   end

   ila_state_t            state_q, state_d;
   logic [OC_W-1:0]       oc_q, oc_d;
   logic [MC_W-1:0]       mc_q, mc_d;
   logic [ILA_CFG_W-1:0]  cfg_q, cfg_d;

   logic                  emit;
   logic [7:0]            data_d;
   logic                  k_d;
   logic                  done_d;

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
      state_d = state_q;
      oc_d    = oc_q;
      mc_d    = mc_q;
      cfg_d   = cfg_q;
      emit    = 1'b0;

      if (i_abort) begin
         state_d = ILA_IDLE;
         oc_d    = '0;
         mc_d    = '0;
      end else begin
         unique case (state_q)
            ILA_IDLE: begin
               if (i_start) begin
                  cfg_d   = i_cfg;
                  state_d = ILA_RUN;
                  oc_d    = '0;
                  mc_d    = '0;
                  emit    = 1'b1;
               end
            end
            ILA_RUN: begin
               if (oc_q == OC_LAST && mc_q == MC_LAST) begin
                  state_d = ILA_IDLE;
                  oc_d    = '0;
                  mc_d    = '0;
               end else begin
                  emit = 1'b1;
                  if (oc_q == OC_LAST) begin
                     oc_d = '0;
                     mc_d = mc_q + MC_W'(1);
                  end else begin
                     oc_d = oc_q + OC_W'(1);
                  end
               end
            end
            default: state_d = ILA_IDLE;
         endcase
      end
   end

   // Octet content is chosen for the position about to be presented (oc_d, mc_d)
   always_comb begin
      data_d = 8'h00;
      k_d    = 1'b0;
      done_d = 1'b0;

      if (emit) begin
         done_d = (oc_d == OC_LAST) && (mc_d == MC_LAST);
         if (oc_d == '0) begin
            data_d = K28_0_R;
            k_d    = 1'b1;
         end else if (oc_d == OC_LAST) begin
            data_d = K28_3_A;
            k_d    = 1'b1;
         end else if (mc_d == MC_CFG && oc_d == OC_W'(1)) begin
            data_d = K28_4_Q;
            k_d    = 1'b1;
         end else begin
            data_d = 8'(oc_d);
            if (mc_d == MC_CFG) begin
               for (int n = 0; n < ILA_CFG_OCTETS; n++) begin
                  if (oc_d == OC_W'(n + ILA_CFG_START_OCT)) begin
                     data_d = cfg_d[8*n +: 8];
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ILA_IDLE;
         oc_q    <= '0;
         mc_q    <= '0;
         // NOTE: the config holding register is reset too; it is small and keeps post-reset state deterministic.
         cfg_q   <= '0;
         o_data  <= 8'h00;
         o_vld   <= 1'b0;
         o_k     <= 1'b0;
         o_busy  <= 1'b0;
         o_done  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         oc_q    <= oc_d;
         mc_q    <= mc_d;
         cfg_q   <= cfg_d;
         o_data  <= data_d;
         o_vld   <= emit;
         o_k     <= k_d;
         o_busy  <= emit;
         o_done  <= done_d;
      end
   end

endmodule

// File: tb/tb_ila_seq_gen.sv
// Scoreboard bench for ila_seq_gen: default build plus an F=1,K=17 build
// driven by the same stimulus, each checked against a position-based model.
module tb_ila_seq_gen;

   localparam int TOTAL_A = 2 * 16 * 4;
   localparam int TOTAL_B = 1 * 17 * 4;

   typedef struct packed {
      logic [7:0] data;
      logic       k;
      logic       done;
   } oct_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         i_start;
   logic         i_abort;
   logic [111:0] i_cfg;

   logic [7:0] a_data, b_data;
   logic       a_vld, a_k, a_busy, a_done;
   logic       b_vld, b_k, b_busy, b_done;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   rem_a    = 0;
   int   rem_b    = 0;
   oct_t q_a[$];
   oct_t q_b[$];
   logic [111:0] base_cfg;

   always #5 clk = ~clk;

   ila_seq_gen u_dut_a (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_cfg(i_cfg),
      .o_data(a_data), .o_vld(a_vld), .o_k(a_k), .o_busy(a_busy), .o_done(a_done)
   );

   ila_seq_gen #(.F(1), .K(17), .NUM_MF(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort), .i_cfg(i_cfg),
      .o_data(b_data), .o_vld(b_vld), .o_k(b_k), .o_busy(b_busy), .o_done(b_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   // Expected octet i of an ILAS, from its multiframe/octet position
   function automatic oct_t ila_octet(int i, int f, int k, int nmf, logic [111:0] cfg);
      oct_t r;
      int   fk = f * k;
      int   mf = i / fk;
      int   oc = i % fk;
      r.done = (i == nmf * fk - 1);
      r.k    = 1'b0;
      r.data = 8'(oc);
      if (oc == 0) begin
         r.data = 8'h1C; r.k = 1'b1;
      end else if (oc == fk - 1) begin
         r.data = 8'h7C; r.k = 1'b1;
      end else if (mf == 1 && oc == 1) begin
         r.data = 8'h9C; r.k = 1'b1;
      end else if (mf == 1 && oc >= 2 && oc <= 15) begin
         r.data = cfg[8*(oc-2) +: 8];
      end
      return r;
   endfunction

   // Model step at each rising edge: rem_* counts octets left from the displayed one
   task automatic model_edge();
      if (!rst_n || i_abort) begin
         rem_a = 0; rem_b = 0;
         q_a.delete(); q_b.delete();
      end else begin
         if (rem_a == 0) begin
            if (i_start) begin
               rem_a = TOTAL_A;
               for (int i = 0; i < TOTAL_A; i++) q_a.push_back(ila_octet(i, 2, 16, 4, i_cfg));
            end
         end else rem_a--;
         if (rem_b == 0) begin
            if (i_start) begin
               rem_b = TOTAL_B;
               for (int i = 0; i < TOTAL_B; i++) q_b.push_back(ila_octet(i, 1, 17, 4, i_cfg));
            end
         end else rem_b--;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      i_start = 1'b0;
      i_abort = 1'b0;
   endtask

   task automatic cycle(input bit s, input bit a);
      i_start = s;
      i_abort = a;
      tick();
   endtask

   task automatic advance_to(input int idx);
      int n = 0;
      while (TOTAL_A - rem_a != idx && n < 400) begin tick(); n++; end
      if (TOTAL_A - rem_a != idx) check("advance_timeout", 32'(TOTAL_A - rem_a), 32'(idx));
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((rem_a != 0 || rem_b != 0) && n < 400) begin tick(); n++; end
      if (rem_a != 0 || rem_b != 0) check("idle_timeout", 32'(rem_a + rem_b), 32'd0);
      repeat (2) tick();
   endtask

   task automatic mon(input string tag, input logic vld, input logic busy, input logic done,
                      input logic k, input logic [7:0] data, input bit ev, input oct_t e);
      check({tag, ".vld"}, 32'(vld), 32'(ev));
      check({tag, ".busy"}, 32'(busy), 32'(ev));
      if (ev) begin
         check({tag, ".data"}, 32'(data), 32'(e.data));
         check({tag, ".k"}, 32'(k), 32'(e.k));
         check({tag, ".done"}, 32'(done), 32'(e.done));
      end else begin
         check({tag, ".idle_data"}, 32'(data), 32'd0);
         check({tag, ".idle_k"}, 32'(k), 32'd0);
         check({tag, ".idle_done"}, 32'(done), 32'd0);
      end
   endtask

   always @(negedge clk) begin : mon_a
      oct_t e;
      e = '0;
      if (rem_a > 0 && q_a.size() > 0) e = q_a.pop_front();
      mon("a", a_vld, a_busy, a_done, a_k, a_data, rem_a > 0, e);
   end

   always @(negedge clk) begin : mon_b
      oct_t e;
      e = '0;
      if (rem_b > 0 && q_b.size() > 0) e = q_b.pop_front();
      mon("b", b_vld, b_busy, b_done, b_k, b_data, rem_b > 0, e);
   end

   initial begin
      for (int n = 0; n < 14; n++) base_cfg[8*n +: 8] = 8'(8'h10 + n);
      rst_n   = 1'b0;
      i_start = 1'b0;
      i_abort = 1'b0;
      i_cfg   = base_cfg;
      #2;
      check("reset.vld", 32'(a_vld), 32'd0);
      check("reset.data", 32'(a_data), 32'd0);
      check("reset.k", 32'(a_k), 32'd0);
      check("reset.busy", 32'(a_busy), 32'd0);
      check("reset.done", 32'(a_done), 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (3) tick();

      // Plain ILAS
      cycle(1'b1, 1'b0);
      wait_idle();

      // Start while busy and on the done cycle are ignored; start right after done runs
      cycle(1'b1, 1'b0);
      advance_to(40);
      cycle(1'b1, 1'b0);
      advance_to(TOTAL_A - 1);
      cycle(1'b1, 1'b0);
      cycle(1'b1, 1'b0);
      wait_idle();

      // Abort mid-sequence, then start and abort together
      cycle(1'b1, 1'b0);
      advance_to(70);
      cycle(1'b0, 1'b1);
      repeat (3) tick();
      cycle(1'b1, 1'b1);
      repeat (4) tick();

      // Config input changes after start are not seen
      cycle(1'b1, 1'b0);
      advance_to(10);
      i_cfg = '1;
      wait_idle();
      i_cfg = base_cfg;

      // Randomised config with sporadic start and abort noise
      for (int r = 0; r < 4; r++) begin
         for (int n = 0; n < 14; n++) i_cfg[8*n +: 8] = 8'($urandom);
         cycle(1'b1, 1'b0);
         for (int c = 0; c < 150; c++) begin
            cycle($urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
            if ($urandom_range(0, 31) == 0) i_cfg[8*$urandom_range(0, 13) +: 8] = 8'($urandom);
         end
         wait_idle();
      end
      i_cfg = base_cfg;

      // Asynchronous reset mid-ILAS
      cycle(1'b1, 1'b0);
      advance_to(50);
      #2;
      rst_n = 1'b0;
      rem_a = 0; rem_b = 0;
      q_a.delete(); q_b.delete();
      #1;
      check("async_rst.a_vld", 32'(a_vld), 32'd0);
      check("async_rst.a_data", 32'(a_data), 32'd0);
      check("async_rst.a_busy", 32'(a_busy), 32'd0);
      check("async_rst.b_vld", 32'(b_vld), 32'd0);
      check("async_rst.b_data", 32'(b_data), 32'd0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (5) tick();
      cycle(1'b1, 1'b0);
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
